// File: rtl/camera_scroll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : camera_scroll_ctrl_pkg
// Description : Camera FSM states and scroll geometry shared with the map
//               renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package camera_scroll_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SCROLL_UP   = 2'd1,
    ST_SCROLL_DOWN = 2'd2,
    ST_HOLD        = 2'd3
  } scroll_state_t;

  localparam int DEF_MAP_HEIGHT  = 470;
  localparam int DEF_SCROLL_STEP = 4;
  localparam int DEF_OFFSET_MAX  = 60;

endpackage : camera_scroll_ctrl_pkg
`default_nettype wire

// File: rtl/camera_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : camera_scroll_ctrl
// Description : Frame-paced camera sequencer: tracks player height, animates
//               the wall offset and commits level changes on frame ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module camera_scroll_ctrl
  import camera_scroll_ctrl_pkg::*;
#(
  parameter int PHY_WIDTH     = 16,
  parameter int CAMERA_WIDTH  = 6,
  parameter int MAP_HEIGHT    = DEF_MAP_HEIGHT,
  parameter int MAX_LEVEL     = 63,
  parameter int SCROLL_STEP   = DEF_SCROLL_STEP,
  parameter int OFFSET_MAX    = DEF_OFFSET_MAX,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    freeze,
  input  logic [PHY_WIDTH-1:0]    player_world_y,
  output logic [CAMERA_WIDTH-1:0] camera_y,
  output logic [CAMERA_WIDTH-1:0] camera_offset,
  output logic [PHY_WIDTH-1:0]    level_base,
  output logic                    scrolling,
  output logic                    level_pulse
);

  localparam int c_hold_w = (SETTLE_FRAMES < 2) ? 1 : $clog2(SETTLE_FRAMES + 1);

  localparam logic [PHY_WIDTH-1:0]    c_map_height = PHY_WIDTH'(MAP_HEIGHT);
  localparam logic [CAMERA_WIDTH-1:0] c_max_level  = CAMERA_WIDTH'(MAX_LEVEL);
  localparam logic [CAMERA_WIDTH-1:0] c_step       = CAMERA_WIDTH'(SCROLL_STEP);
  localparam logic [CAMERA_WIDTH-1:0] c_offset_max = CAMERA_WIDTH'(OFFSET_MAX);
  localparam logic [CAMERA_WIDTH-1:0] c_cam_one    = CAMERA_WIDTH'(1);
  localparam logic [c_hold_w-1:0]     c_settle     = c_hold_w'(SETTLE_FRAMES);
  localparam logic [c_hold_w-1:0]     c_hold_one   = c_hold_w'(1);

  scroll_state_t             r_state, w_state_nxt;
  logic [CAMERA_WIDTH-1:0]   r_camera_y, w_camera_y_nxt;
  logic [CAMERA_WIDTH-1:0]   r_offset, w_offset_nxt;
  logic [PHY_WIDTH-1:0]      r_level_base, w_level_base_nxt;
  logic                      r_level_pulse, w_level_pulse_nxt;
  logic [c_hold_w-1:0]       r_hold_cnt, w_hold_cnt_nxt;

  logic                      w_tick;
  logic [PHY_WIDTH:0]        w_base_top;
  logic                      w_up_req;
  logic                      w_dn_req;
  logic [c_hold_w-1:0]       w_hold_inc;

  assign w_tick     = frame_tick & ~freeze;
  // One extra bit so the top of the highest window cannot wrap past zero.
  assign w_base_top = {1'b0, r_level_base} + {1'b0, c_map_height};
  assign w_up_req   = ({1'b0, player_world_y} >= w_base_top) && (r_camera_y < c_max_level);
  assign w_dn_req   = (player_world_y < r_level_base) && (r_camera_y != '0);
  assign w_hold_inc = r_hold_cnt + c_hold_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_camera_y    <= '0;
      r_offset      <= '0;
      r_level_base  <= '0;
      r_level_pulse <= 1'b0;
      r_hold_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_camera_y    <= w_camera_y_nxt;
      r_offset      <= w_offset_nxt;
      r_level_base  <= w_level_base_nxt;
      r_level_pulse <= w_level_pulse_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_camera_y_nxt    = r_camera_y;
    w_offset_nxt      = r_offset;
    w_level_base_nxt  = r_level_base;
    w_level_pulse_nxt = 1'b0;
    w_hold_cnt_nxt    = r_hold_cnt;

    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_up_req) begin
            w_state_nxt = ST_SCROLL_UP;
          end else if (w_dn_req) begin
            // Going down, the level drops first and the wall scrolls back in.
            w_state_nxt       = ST_SCROLL_DOWN;
            w_camera_y_nxt    = r_camera_y - c_cam_one;
            w_level_base_nxt  = r_level_base - c_map_height;
            w_offset_nxt      = c_offset_max;
            w_level_pulse_nxt = 1'b1;
          end
        end
        ST_SCROLL_UP: begin
          if (r_offset < c_offset_max) begin
            w_offset_nxt = r_offset + c_step;
          end else begin
            w_state_nxt       = ST_HOLD;
            w_camera_y_nxt    = r_camera_y + c_cam_one;
            w_level_base_nxt  = r_level_base + c_map_height;
            w_offset_nxt      = '0;
            w_level_pulse_nxt = 1'b1;
            w_hold_cnt_nxt    = '0;
          end
        end
        ST_SCROLL_DOWN: begin
          if (r_offset != '0) begin
            w_offset_nxt = r_offset - c_step;
          end else begin
            w_state_nxt    = ST_HOLD;
            w_hold_cnt_nxt = '0;
          end
        end
        ST_HOLD: begin
          if (w_hold_inc >= c_settle) begin
            w_state_nxt    = ST_IDLE;
            w_hold_cnt_nxt = '0;
          end else begin
            w_hold_cnt_nxt = w_hold_inc;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign camera_y      = r_camera_y;
  assign camera_offset = r_offset;
  assign level_base    = r_level_base;
  assign level_pulse   = r_level_pulse;
  assign scrolling     = (r_state == ST_SCROLL_UP) || (r_state == ST_SCROLL_DOWN);

endmodule : camera_scroll_ctrl
`default_nettype wire

// File: doc/camera_scroll_ctrl.md
Name: camera_scroll_ctrl

Overview:
Sequences the map renderer's camera. It tracks the player's absolute world height and drives camera_y (the level index, shown as the level number) and camera_offset (the pixel scroll applied to the top wall). When the player leaves the current level window it plays a frame-paced scroll animation and then commits the level change. It sits between the physics block and the map/VGA renderer, and updates only on frame ticks so the picture never tears mid-frame.

Parameters:
PHY_WIDTH, 16, width of world/physics coordinates
CAMERA_WIDTH, 6, width of camera_y and camera_offset
MAP_HEIGHT, 470, world pixels per level
MAX_LEVEL, 63, highest legal camera_y (must be < 2^CAMERA_WIDTH)
SCROLL_STEP, 4, offset change per frame tick during a scroll
OFFSET_MAX, 60, offset end-point; a multiple of SCROLL_STEP and < 2^CAMERA_WIDTH
SETTLE_FRAMES, 2, frame ticks spent in HOLD after a scroll (anti ping-pong)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame (end of active area)
freeze  in  1  pause; frame_tick is ignored while high
player_world_y  in  PHY_WIDTH  player absolute height, 0 = bottom of level 0
camera_y  out  CAMERA_WIDTH  current level index (registered)
camera_offset  out  CAMERA_WIDTH  current scroll offset (registered)
level_base  out  PHY_WIDTH  camera_y*MAP_HEIGHT, for world-to-map conversion (registered)
scrolling  out  1  high in SCROLL_UP and SCROLL_DOWN
level_pulse  out  1  one-cycle pulse in the cycle camera_y changes

Behaviour:
- Reset (asynchronous, any state, including mid-scroll): state=IDLE, camera_y=0, camera_offset=0, level_base=0, scrolling=0, level_pulse=0, hold counter=0.
- "tick" means frame_tick & ~freeze. No state, counter or output changes except on a tick. level_pulse deasserts unconditionally on the next cycle after it fires.
- Compares are combinational on registered level_base. All sums are computed at PHY_WIDTH+1 bits so no wrap occurs.
  - up_req = player_world_y >= level_base + MAP_HEIGHT, and camera_y < MAX_LEVEL.
  - dn_req = player_world_y < level_base, and camera_y > 0.
- IDLE, on a tick:
  - If up_req, go to SCROLL_UP; offset stays 0.
  - Else if dn_req, go to SCROLL_DOWN. On the same edge: camera_y -= 1, level_base -= MAP_HEIGHT, camera_offset = OFFSET_MAX, level_pulse = 1.
  - up_req and dn_req are mutually exclusive. If neither holds, stay in IDLE.
- SCROLL_UP, on a tick:
  - If offset < OFFSET_MAX, then offset += SCROLL_STEP.
  - Else commit: camera_y += 1, level_base += MAP_HEIGHT, offset = 0, level_pulse = 1, go to HOLD.
  - With the defaults, the commit lands on the 16th tick after entry.
- SCROLL_DOWN, on a tick:
  - If offset > 0, then offset -= SCROLL_STEP.
  - Else go to HOLD.
  - With the defaults, HOLD is entered on the 16th tick after entry.
- A scroll always completes. player_world_y is not sampled during a scroll, even if the player reverses direction.
- HOLD: the counter loads 0 on entry and increments on each tick. When it reaches SETTLE_FRAMES, go to IDLE. A multi-level jump therefore advances one level per scroll+hold cycle.
- Saturation: no up_req at MAX_LEVEL and no dn_req at 0. camera_y never wraps.
- Invariants: camera_offset ≤ OFFSET_MAX always; camera_offset = 0 in IDLE and HOLD; level_base == camera_y*MAP_HEIGHT always.

Decomposition:
- Shared package:
  - State enum IDLE/SCROLL_UP/SCROLL_DOWN/HOLD (2 bits).
  - Default MAP_HEIGHT, SCROLL_STEP, OFFSET_MAX constants, shared with the map renderer.
- Optional sub-module: frame_tick_gen, which derives frame_tick from the VGA vertical counter.
- The controller itself is a single module: FSM plus offset, level, base and hold registers.

Test Plan:
- Reset, player_world_y=100, 10 ticks -> camera_y=0, offset=0, scrolling=0, level_pulse never fires.
- player_world_y=470, then ticks -> scrolling=1, offset 4,8,…,60. On the 16th tick: camera_y=1, level_base=470, offset=0, one level_pulse. After 2 more ticks: IDLE.
- From camera_y=1, set player_world_y=469, one tick -> camera_y=0, offset=60, level_pulse. Offset ramps down to 0, then HOLD, then IDLE.
- During SCROLL_UP at offset=28, hold freeze=1 for 5 frame_ticks -> offset stays 28. After freeze drops, the scroll resumes at 32.
- Assert rst asynchronously mid-scroll (offset=40, camera_y=3) -> all outputs are 0 immediately, without waiting for a clock edge.
- camera_y=63, player_world_y=65535 -> no scroll, no pulse, stays IDLE. player_world_y=3000 from 0 -> 6 successive scrolls end at camera_y=6 with 6 level_pulses.
